cnu_serial: RTL and testbench



---
 rtl/ldpc_pkg.sv | 38 +++
 rtl/cnu_sat.sv | 24 ++
 rtl/cnu_serial.sv | 123 ++++++++++++
 tb/tb_cnu_serial.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared LDPC definitions: default message widths, saturation and sign/magnitude
// helpers, and the check-node FSM state type.
package ldpc_pkg;

    localparam int DATA_W = 6;
    localparam int EXT_W  = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } cnu_state_t;

    // Clamp a wide two's-complement value into the symmetric range +-(2^mag_bits - 1).
    function automatic int sat_narrow(input int v, input int mag_bits);
        int maxmag;
        maxmag = (1 << mag_bits) - 1;
        if (v > maxmag) begin
            return maxmag;
        end
        if (v < -maxmag) begin
            return -maxmag;
        end
        return v;
    endfunction

    function automatic logic sm_sign(input int v);
        return v < 0;
    endfunction

    function automatic int sm_mag(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sm_merge(input logic s, input int m);
        return s ? -m : m;
    endfunction

endpackage

// File: rtl/cnu_sat.sv
// Combinational input stage: saturates a variable-to-check message and splits it
// into sign and magnitude.
module cnu_sat
    import ldpc_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int ext_w  = EXT_W
) (
    input  logic [data_w+ext_w-1:0] in_q,
    output logic                    sign,
    output logic [data_w-2:0]       mag
);

    localparam int mag_w = data_w - 1;

    int clamped;

    always_comb begin
        clamped = sat_narrow(int'($signed(in_q)), mag_w);
        sign    = sm_sign(clamped);
        mag     = mag_w'(sm_mag(clamped));
    end

endmodule

// File: rtl/cnu_serial.sv
// Serial min-sum check node: collects K messages tracking min1/min2/idx1/parity,
// then emits K check-to-variable messages.
module cnu_serial
    import ldpc_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int ext_w  = EXT_W,
    parameter int K      = 6,
    parameter int OFFSET = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [data_w+ext_w-1:0] in_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [data_w-1:0]       out_r,
    output logic                    out_last
);

    localparam int                mag_w    = data_w - 1;
    localparam int                cnt_w    = (K > 1) ? $clog2(K) : 1;
    localparam logic [cnt_w-1:0]  last_idx = cnt_w'(K - 1);
    localparam logic [mag_w-1:0]  max_mag  = '1;

    cnu_state_t       state;
    logic [cnt_w-1:0] in_cnt;
    logic [cnt_w-1:0] out_cnt;
    logic [cnt_w-1:0] idx1;
    logic [mag_w-1:0] min1;
    logic [mag_w-1:0] min2;
    logic             parity;
    logic [K-1:0]     sign_q;

    logic             s_sign;
    logic [mag_w-1:0] s_mag;

    cnu_sat #(
        .data_w(data_w),
        .ext_w (ext_w)
    ) u_sat (
        .in_q(in_q),
        .sign(s_sign),
        .mag (s_mag)
    );

    assign in_ready  = (state == COLLECT) && !rst;
    assign out_valid = (state == EMIT);

    // NOTE: state registers use non-blocking assignments so every update in this
    // block sees the pre-edge values (e.g. min2 <= min1 takes the old min1).
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COLLECT;
            in_cnt  <= '0;
            out_cnt <= '0;
            idx1    <= '0;
            min1    <= max_mag;
            min2    <= max_mag;
            parity  <= 1'b0;
            // NOTE: the sign vector is fully rewritten by every row before it is
            // read; clearing it here only gives a deterministic post-reset state.
            sign_q  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        sign_q[in_cnt] <= s_sign;
                        parity         <= parity ^ s_sign;
                        // Strict compares keep the earliest index on ties.
                        if (s_mag < min1) begin
                            min2 <= min1;
                            min1 <= s_mag;
                            idx1 <= in_cnt;
                        end else if (s_mag < min2) begin
                            min2 <= s_mag;
                        end
                        if (in_cnt == last_idx) begin
                            state  <= EMIT;
                            in_cnt <= '0;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_cnt == last_idx) begin
                            state   <= COLLECT;
                            out_cnt <= '0;
                            idx1    <= '0;
                            min1    <= max_mag;
                            min2    <= max_mag;
                            parity  <= 1'b0;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    logic [mag_w-1:0] m;
    logic [mag_w-1:0] m_off;
    logic             s_out;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        m        = (out_cnt == idx1) ? min2 : min1;
        m_off    = (int'(m) > OFFSET) ? mag_w'(int'(m) - OFFSET) : '0;
        s_out    = parity ^ sign_q[out_cnt];
        out_r    = '0;
        out_last = 1'b0;
        if (state == EMIT) begin
            out_r    = data_w'(sm_merge(s_out, int'(m_off)));
            out_last = (out_cnt == last_idx);
        end
    end

endmodule

// File: tb/tb_cnu_serial.sv
// Self-checking bench for cnu_serial: three instances (OFFSET 0, 1, 5) share one
// stimulus stream; directed table rows, backpressure/reset sequences, random rows.
module tb_cnu_serial;

    localparam int data_w = 6;
    localparam int ext_w  = 3;
    localparam int K      = 4;
    localparam int sum_w  = data_w + ext_w;

    typedef int row_t [4];
    typedef logic signed [15:0] w16_t;
    typedef w16_t [0:3] w4_t;
    typedef struct packed {
        w4_t in_v;
        w4_t e0;
        w4_t e1;
        w4_t e5;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [sum_w-1:0] in_q = '0;
    logic [2:0]       in_ready;
    logic [2:0]       out_valid;
    logic [2:0]       out_last;
    logic [data_w-1:0] out_r [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cnu_serial #(.data_w(data_w), .ext_w(ext_w), .K(K), .OFFSET(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_q(in_q),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_r(out_r[0]), .out_last(out_last[0])
    );
    cnu_serial #(.data_w(data_w), .ext_w(ext_w), .K(K), .OFFSET(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_q(in_q),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_r(out_r[1]), .out_last(out_last[1])
    );
    cnu_serial #(.data_w(data_w), .ext_w(ext_w), .K(K), .OFFSET(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_q(in_q),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_r(out_r[2]), .out_last(out_last[2])
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int s6(input logic [data_w-1:0] x);
        return int'($signed(x));
    endfunction

    function automatic w4_t q(input int a, input int b, input int c, input int d);
        w4_t r;
        r[0] = 16'(a);
        r[1] = 16'(b);
        r[2] = 16'(c);
        r[3] = 16'(d);
        return r;
    endfunction

    // Leave-one-out reference: output i is the product of the other signs and the
    // smallest of the other saturated magnitudes, offset and floored at zero.
    function automatic int model(input row_t v, input int i, input int off);
        int best;
        int neg;
        int c;
        best = 1 << 30;
        neg  = 0;
        for (int j = 0; j < K; j++) begin
            if (j != i) begin
                c = (v[j] > 31) ? 31 : (v[j] < -31) ? -31 : v[j];
                if (c < 0) begin
                    neg ^= 1;
                    c = -c;
                end
                if (c < best) best = c;
            end
        end
        best = (best > off) ? best - off : 0;
        return (neg != 0) ? -best : best;
    endfunction

    task automatic push(input int v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_q     = sum_w'(v);
        while (in_ready[0] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready[0] !== 1'b1) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_row(input row_t in_v, input row_t e0, input row_t e1, input row_t e5,
                           input bit stall, input bit rand_bp, input bit hold_valid);
        int n;
        int ns;
        for (int i = 0; i < K; i++) push(in_v[i]);
        check("first_out_latency", out_valid, 3'b111);
        in_valid = hold_valid;
        in_q     = '0;
        for (int i = 0; i < K; i++) begin
            n = 0;
            while (out_valid[0] !== 1'b1 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            ns = (stall && i == 1) ? 3 : (rand_bp ? int'($urandom_range(0, 2)) : 0);
            out_ready = (ns == 0);
            for (int s = 0; s < ns; s++) begin
                check($sformatf("hold_r[%0d]", i), s6(out_r[0]), e0[i]);
                check($sformatf("hold_last[%0d]", i), int'(out_last[0]), (i == K-1) ? 1 : 0);
                check("hold_in_ready", in_ready, 3'b000);
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            check($sformatf("out_valid[%0d]", i), out_valid, 3'b111);
            check($sformatf("r_off0[%0d]", i), s6(out_r[0]), e0[i]);
            check($sformatf("r_off1[%0d]", i), s6(out_r[1]), e1[i]);
            check($sformatf("r_off5[%0d]", i), s6(out_r[2]), e5[i]);
            check($sformatf("out_last[%0d]", i), out_last, (i == K-1) ? 3'b111 : 3'b000);
            check($sformatf("emit_in_ready[%0d]", i), in_ready, 3'b000);
            @(posedge clk); #1;
        end
        check("turnaround_in_ready", in_ready, 3'b111);
        check("idle_out_valid", out_valid, 3'b000);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        row_t a, b, c, d;

        tbl[0] = '{in_v: q(10, -3, 7, -20), e0: q(3, -7, 3, -3),
                   e1: q(2, -6, 2, -2),     e5: q(0, -2, 0, 0)};
        tbl[1] = '{in_v: q(200, -256, 5, 5), e0: q(-5, 5, -5, -5),
                   e1: q(-4, 4, -4, -4),     e5: q(0, 0, 0, 0)};
        tbl[2] = '{in_v: q(0, 1, 2, 3), e0: q(1, 0, 0, 0),
                   e1: q(0, 0, 0, 0),   e5: q(0, 0, 0, 0)};
        tbl[3] = '{in_v: q(3, 3, 3, 3), e0: q(3, 3, 3, 3),
                   e1: q(2, 2, 2, 2),   e5: q(0, 0, 0, 0)};

        // Reset state
        #1;
        check("rst_in_ready", in_ready, 3'b000);
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 3'b000);
        check("rst_out_r", s6(out_r[0]), 0);
        check("rst_out_last", out_last, 3'b000);
        check("rst_in_ready_held", in_ready, 3'b000);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 3'b111);

        // Directed table
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < K; i++) begin
                a[i] = int'($signed(tbl[r].in_v[i]));
                b[i] = int'($signed(tbl[r].e0[i]));
                c[i] = int'($signed(tbl[r].e1[i]));
                d[i] = int'($signed(tbl[r].e5[i]));
            end
            run_row(a, b, c, d, 1'b0, 1'b0, 1'b0);
        end

        // Backpressure on the 2nd output, in_valid held high throughout emission
        for (int i = 0; i < K; i++) begin
            a[i] = int'($signed(tbl[0].in_v[i]));
            b[i] = int'($signed(tbl[0].e0[i]));
            c[i] = int'($signed(tbl[0].e1[i]));
            d[i] = int'($signed(tbl[0].e5[i]));
        end
        run_row(a, b, c, d, 1'b1, 1'b0, 1'b1);

        // Mid-row reset discards partial state
        push(5);
        push(-9);
        in_valid = 1'b1;
        in_q     = sum_w'(77);
        rst      = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 3'b000);
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 3'b000);
        check("midrst_out_r", s6(out_r[0]), 0);
        check("midrst_out_last", out_last, 3'b000);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_in_ready_after", in_ready, 3'b111);
        @(posedge clk); #1;
        check("midrst_idle_valid", out_valid, 3'b000);
        run_row(a, b, c, d, 1'b0, 1'b0, 1'b0);

        // Random rows against the leave-one-out model
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < K; i++) begin
                if (r % 2 == 0) a[i] = int'($urandom_range(0, 511)) - 256;
                else            a[i] = int'($urandom_range(0, 16)) - 8;
            end
            for (int i = 0; i < K; i++) begin
                b[i] = model(a, i, 0);
                c[i] = model(a, i, 1);
                d[i] = model(a, i, 5);
            end
            run_row(a, b, c, d, 1'b0, 1'b1, r[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
